reg_display_scanner: RTL and testbench

Downstream consumer of the register file's I/O export: takes the 256-bit `from_reg` bundle (registers $3–$10) and the `reg_IO_out_ena` flag and drives an 8-digit multiplexed 7-segment display. The display shows one selected 32-bit register word as 8 hex digits. Two debounced pushbuttons step the selected word forward or back. When `reg_IO_out_ena` is low, the displayed contents freeze on the last captured snapshot.

---
 rtl/reg_disp_pkg.sv | 40 ++++
 rtl/btn_debounce.sv | 66 ++++++
 rtl/reg_display_scanner.sv | 97 +++++++++
 tb/tb_reg_display_scanner.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_disp_pkg.sv
// Shared constants, debounce states and the hex-to-7-segment table
// for the register-file display scanner.
package reg_disp_pkg;

  localparam int NUM_WORDS = 8;
  localparam int FIRST_REG = 3;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_WAIT_PRESS,
    DB_PRESSED,
    DB_WAIT_RELEASE
  } db_state_e;

  // Active-high segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h00;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus press/release debounce FSM.
// Emits a single-cycle pulse per accepted press.
module btn_debounce
  import reg_disp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic            s1_q, s2_q;
  db_state_e       st_q, st_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      st_q  <= DB_IDLE;
      cnt_q <= '0;
    end else begin
      s1_q  <= btn_i;
      s2_q  <= s1_q;
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    pulse_o = 1'b0;
    unique case (st_q)
      DB_IDLE: begin
        if (s2_q) begin
          st_d  = DB_WAIT_PRESS;
          cnt_d = '0;
        end
      end
      DB_WAIT_PRESS: begin
        if (!s2_q) st_d = DB_IDLE;
        else if (cnt_q == LAST) st_d = DB_PRESSED;
        else cnt_d = cnt_q + 1'b1;
      end
      DB_PRESSED: begin
        pulse_o = 1'b1;
        st_d    = DB_WAIT_RELEASE;
        cnt_d   = '0;
      end
      DB_WAIT_RELEASE: begin
        // Any bounce back to 1 restarts the release window
        if (s2_q) cnt_d = '0;
        else if (cnt_q == LAST) st_d = DB_IDLE;
        else cnt_d = cnt_q + 1'b1;
      end
      default: st_d = DB_IDLE;
    endcase
  end

endmodule

// File: rtl/reg_display_scanner.sv
// Shows one snapshot register word as 8 hex digits on a
// multiplexed 7-segment display; buttons browse the words.
module reg_display_scanner
  import reg_disp_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] from_reg,
  input  logic         reg_IO_out_ena,
  input  logic         btn_next,
  input  logic         btn_prev,
  output logic [7:0]   seg_an,
  output logic [7:0]   seg_cat,
  output logic [2:0]   sel_word,
  output logic [7:0]   sel_led
);

  localparam int SW = $clog2(NUM_WORDS);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(SCAN_DIV - 1);

  logic [255:0]  shadow_q;
  logic [SW-1:0] sel_q, sel_d;
  logic [2:0]    dig_q, dig_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    cat_q, cat_d;
  logic          nxt, prv, dp_on;
  logic [31:0]   word;
  logic [3:0]    nib;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_next),
    .pulse_o (nxt)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_prev),
    .pulse_o (prv)
  );

  always_comb begin
    sel_d = sel_q;
    unique case (1'b1)
      nxt && !prv: sel_d = sel_q + 1'b1;
      prv && !nxt: sel_d = sel_q - 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    pre_d = pre_q + 1'b1;
    dig_d = dig_q;
    if (pre_q == PLAST) begin
      pre_d = '0;
      dig_d = dig_q + 1'b1;
    end
  end

  // Browsing always reads the shadow, so it works while frozen
  assign word  = shadow_q[{sel_q, 5'd0} +: 32];
  assign nib   = word[{dig_q, 2'd0} +: 4];
  assign dp_on = (dig_q == 3'd7) && !reg_IO_out_ena;
  assign an_d  = ~(8'b1 << dig_q);
  assign cat_d = {~dp_on, ~hex7(nib)};

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      sel_q    <= '0;
      dig_q    <= '0;
      pre_q    <= '0;
      an_q     <= 8'hFF;
      cat_q    <= 8'hFF;
    end else begin
      if (reg_IO_out_ena) shadow_q <= from_reg;
      sel_q <= sel_d;
      dig_q <= dig_d;
      pre_q <= pre_d;
      an_q  <= an_d;
      cat_q <= cat_d;
    end
  end

  assign seg_an   = an_q;
  assign seg_cat  = cat_q;
  assign sel_word = sel_q;
  assign sel_led  = 8'b1 << sel_q;

endmodule

// File: tb/tb_reg_display_scanner.sv
// Bench for reg_display_scanner with short scan and debounce
// periods: digit table, freeze, button browsing and reset.
module tb_reg_display_scanner;

  localparam int SD = 4;
  localparam int DB = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] from_reg = '0;
  logic         ena = 1'b0;
  logic         bn = 1'b0;
  logic         bp = 1'b0;
  logic [7:0]   seg_an, seg_cat, sel_led;
  logic [2:0]   sel_word;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [2:0] dig;
    logic [7:0] cat;
    string      nm;
  } exp_t;

  typedef struct {
    logic [31:0] w;
    logic [2:0]  dig;
    logic [7:0]  cat;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[16];
  logic [7:0] segtab[16];

  always #5 clk = ~clk;

  reg_display_scanner #(
    .SCAN_DIV        (SD),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .from_reg       (from_reg),
    .reg_IO_out_ena (ena),
    .btn_next       (bn),
    .btn_prev       (bp),
    .seg_an         (seg_an),
    .seg_cat        (seg_cat),
    .sel_word       (sel_word),
    .sel_led        (sel_led)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] d, input logic [7:0] c,
                      input string nm);
    exp_t e;
    e.dig = d;
    e.cat = c;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  // Pop each expectation and compare when its digit is being driven
  task automatic drain();
    exp_t e;
    logic [7:0] an_exp;
    logic ok;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      an_exp = ~(8'b1 << e.dig);
      ok = 1'b0;
      for (int i = 0; i < 8 * SD + 8; i++) begin
        @(negedge clk);
        if (seg_an == an_exp) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) chk({e.nm, "_timeout"}, {24'd0, seg_an}, {24'd0, an_exp});
      else chk(e.nm, {24'd0, seg_cat}, {24'd0, e.cat});
    end
    #1;
  endtask

  task automatic press(input logic n, input logic p);
    bn = n;
    bp = p;
    cyc(20);
    bn = 1'b0;
    bp = 1'b0;
    cyc(14);
  endtask

  initial begin
    segtab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    for (int i = 0; i < 8; i++) begin
      vecs[i]     = '{32'h76543210, 3'(i), segtab[i]};
      vecs[8 + i] = '{32'hFEDCBA98, 3'(i), segtab[8 + i]};
    end

    // Reset state
    cyc(3);
    @(negedge clk);
    chk("rst_an", {24'd0, seg_an}, 32'hFF);
    chk("rst_cat", {24'd0, seg_cat}, 32'hFF);
    chk("rst_sel", {29'd0, sel_word}, 32'd0);
    chk("rst_led", {24'd0, sel_led}, 32'h01);
    @(posedge clk);
    #1;
    from_reg[31:0] = 32'h1234ABCD;
    ena = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("first_an", {24'd0, seg_an}, 32'hFE);
    chk("first_cat", {24'd0, seg_cat}, 32'hA1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("dig1_an", {24'd0, seg_an}, 32'hFD);
    chk("dig1_cat", {24'd0, seg_cat}, 32'hC6);
    #1;

    // Freeze: snapshot holds, dp lit on digit 7
    ena = 1'b0;
    from_reg[31:0] = 32'h0;
    cyc(3);
    push(0, 8'hA1, "frz_d0");
    push(1, 8'hC6, "frz_d1");
    push(2, 8'h83, "frz_d2");
    push(3, 8'h88, "frz_d3");
    push(4, 8'h99, "frz_d4");
    push(5, 8'hB0, "frz_d5");
    push(6, 8'hA4, "frz_d6");
    push(7, 8'h79, "frz_d7_dp");
    drain();
    ena = 1'b1;
    cyc(3);
    for (int i = 0; i < 8; i++) push(3'(i), 8'hC0, "thaw");
    drain();

    // Segment table over all hex digits
    for (int i = 0; i < 16; i++) begin
      if (i == 0 || i == 8) begin
        from_reg[31:0] = vecs[i].w;
        cyc(3);
      end
      push(vecs[i].dig, vecs[i].cat, "hex_tab");
      drain();
    end

    // Short glitch rejected, long press accepted once
    bn = 1'b1;
    cyc(5);
    bn = 1'b0;
    cyc(14);
    chk("glitch_sel", {29'd0, sel_word}, 32'd0);
    bn = 1'b1;
    cyc(20);
    chk("held_sel", {29'd0, sel_word}, 32'd1);
    chk("held_led", {24'd0, sel_led}, 32'h02);
    bn = 1'b0;
    cyc(14);
    chk("rel_sel", {29'd0, sel_word}, 32'd1);
    from_reg[63:32] = 32'hFFFFFFFF;
    cyc(3);
    for (int i = 0; i < 8; i++) push(3'(i), 8'h8E, "w1_F");
    drain();

    // Wrap forward 1..7 -> 0
    for (int i = 0; i < 7; i++) begin
      press(1'b1, 1'b0);
      chk("wrap_next", {29'd0, sel_word}, (i + 2) % 8);
    end
    press(1'b0, 1'b1);
    chk("prev_wrap", {29'd0, sel_word}, 32'd7);
    chk("prev_led", {24'd0, sel_led}, 32'h80);

    // Simultaneous pulses cancel
    press(1'b1, 1'b1);
    chk("both_sel", {29'd0, sel_word}, 32'd7);
    press(1'b1, 1'b0);
    chk("next_0", {29'd0, sel_word}, 32'd0);

    // Reset mid-debounce, then a held button is accepted once
    press(1'b1, 1'b0);
    chk("pre_rst", {29'd0, sel_word}, 32'd1);
    bn = 1'b1;
    cyc(7);
    rst = 1'b1;
    cyc(2);
    chk("mid_rst_sel", {29'd0, sel_word}, 32'd0);
    rst = 1'b0;
    cyc(6);
    chk("post_rst_early", {29'd0, sel_word}, 32'd0);
    cyc(14);
    chk("post_rst_press", {29'd0, sel_word}, 32'd1);
    bn = 1'b0;
    cyc(14);
    chk("post_rst_rel", {29'd0, sel_word}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
